// File: rtl/fsm_cmd_pkg.sv
// Shared types and helpers for the state-command driver and anything that models it.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package fsm_cmd_pkg;

    // Default command/status width; states are 0 .. 2**W_DEF-1.
    localparam int W_DEF = 3;

    // Widest transition mask the legality helper accepts (covers W up to 4).
    localparam int MASK_MAX = 256;

    // Driver control states.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_ECHO = 2'd2,
        ERROR     = 2'd3
    } drv_state_e;

    // Transition from_s -> to_s is legal when mask bit [from_s*2**w + to_s] is set.
    // The mask is passed zero-extended to MASK_MAX bits so one helper serves any W.
    function automatic logic legal(input logic [MASK_MAX-1:0] mask,
                                   input int unsigned         w,
                                   input int unsigned         from_s,
                                   input int unsigned         to_s);
        logic [MASK_MAX-1:0] sh;
        sh = mask >> (from_s * (32'd1 << w) + to_s);
        return sh[0];
    endfunction

endpackage

// File: rtl/fsm_echo_timer.sv
// Echo window / timeout timer: counts cycles since a command went live.
// Latency: echo_ok / timeout_stb are combinational from the registered count.
// Backpressure: none; clr restarts the count, en advances it (saturating).
module fsm_echo_timer #(
    parameter int ECHO_LAT = 3,
    parameter int TIMEOUT  = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic echo_match,
    output logic echo_ok,
    output logic timeout_stb
);

    localparam int LIMIT = ECHO_LAT + TIMEOUT;
    localparam int CW    = $clog2(LIMIT + 1);

    // First count value at which a matching echo counts as confirmation.
    localparam logic [CW-1:0] WIN_OPEN = CW'(ECHO_LAT - 1);
    // Last count value on which a confirmation is still accepted.
    localparam logic [CW-1:0] LAST     = CW'(LIMIT - 1);
    // Saturation value: the counter never wraps.
    localparam logic [CW-1:0] SAT      = CW'(LIMIT);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: restart on clr, otherwise step while enabled until saturated.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != SAT)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Early echoes are ignored; a match on the last window cycle still beats the timeout.
    always_comb begin
        echo_ok     = en && echo_match && (cnt_q >= WIN_OPEN);
        timeout_stb = en && !echo_ok && (cnt_q >= LAST);
    end

endmodule

// File: rtl/fsm_cmd_driver.sv
// Issues state commands to a downstream fsm and confirms each one through its status echo.
// Latency: accept -> cmd_valid 2 cycles; best case accept -> done_pulse ECHO_LAT+2 cycles.
// Backpressure: req_ready low while a request is in flight and forever after a timeout.
module fsm_cmd_driver
    import fsm_cmd_pkg::*;
#(
    parameter int                   W           = W_DEF,
    parameter int                   ECHO_LAT    = 3,
    parameter int                   TIMEOUT     = 8,
    parameter logic [2**(2*W)-1:0]  ALLOW_MASK  = '1,
    parameter logic [W-1:0]         RESET_STATE = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    input  logic [W-1:0] req_state,
    output logic         req_ready,
    output logic [W-1:0] cmd_out,
    output logic         cmd_valid,
    input  logic [W-1:0] status_in,
    output logic [W-1:0] cur_state,
    output logic         busy,
    output logic         done_pulse,
    output logic         err_illegal,
    output logic         err_timeout
);

    localparam logic [MASK_MAX-1:0] MASK_EXT = MASK_MAX'(ALLOW_MASK);

    drv_state_e   state_q, state_d;
    logic [W-1:0] tgt_q, tgt_d;
    logic [W-1:0] cur_state_q, cur_state_d;
    logic [W-1:0] cmd_out_q, cmd_out_d;
    logic         cmd_valid_q, cmd_valid_d;
    logic         req_ready_q, req_ready_d;
    logic         done_q, done_d;
    logic         err_illegal_q, err_illegal_d;
    logic         err_timeout_q, err_timeout_d;

    logic         accept;
    logic         req_legal;
    logic         req_same;
    logic         tmr_clr;
    logic         tmr_en;
    logic         echo_match;
    logic         echo_ok;
    logic         timeout_stb;

    // Request handshake and its classification against the last confirmed state.
    always_comb begin
        accept     = req_valid && req_ready_q;
        req_legal  = legal(MASK_EXT, W, 32'(cur_state_q), 32'(req_state));
        req_same   = (req_state == cur_state_q);
        tmr_clr    = (state_q == ISSUE);
        tmr_en     = (state_q == WAIT_ECHO);
        echo_match = (status_in == tgt_q);
    end

    fsm_echo_timer #(
        .ECHO_LAT (ECHO_LAT),
        .TIMEOUT  (TIMEOUT)
    ) u_timer (
        .clk         (clk),
        .rst         (rst),
        .clr         (tmr_clr),
        .en          (tmr_en),
        .echo_match  (echo_match),
        .echo_ok     (echo_ok),
        .timeout_stb (timeout_stb)
    );

    // Next-state: only a legal request for a different state issues a command.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept && req_legal && !req_same) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT_ECHO;
            end
            WAIT_ECHO: begin
                if (echo_ok) begin
                    state_d = IDLE;
                end else if (timeout_stb) begin
                    state_d = ERROR;
                end
            end
            ERROR: begin
                state_d = ERROR;
            end
            default: begin
                state_d = ERROR;
            end
        endcase
    end

    // Output/next-register values; pulses default low, everything else holds.
    always_comb begin
        tgt_d         = tgt_q;
        cur_state_d   = cur_state_q;
        cmd_out_d     = cmd_out_q;
        cmd_valid_d   = cmd_valid_q;
        done_d        = 1'b0;
        err_illegal_d = 1'b0;
        err_timeout_d = err_timeout_q;
        // Ready only after a full IDLE cycle, so it rises the cycle after a done pulse.
        req_ready_d   = (state_q == IDLE) && (state_d == IDLE);

        case (state_q)
            IDLE: begin
                if (accept) begin
                    tgt_d = req_state;
                    if (!req_legal) begin
                        err_illegal_d = 1'b1;
                    end else if (req_same) begin
                        done_d = 1'b1;
                    end
                end
            end
            ISSUE: begin
                cmd_out_d   = tgt_q;
                cmd_valid_d = 1'b1;
            end
            WAIT_ECHO: begin
                if (echo_ok) begin
                    cur_state_d = tgt_q;
                    done_d      = 1'b1;
                    cmd_valid_d = 1'b0;
                end else if (timeout_stb) begin
                    err_timeout_d = 1'b1;
                    cmd_valid_d   = 1'b0;
                end
            end
            default: begin
                cmd_valid_d = 1'b0;
            end
        endcase
    end

    // State and all registered outputs; reset drops any in-flight request silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            tgt_q         <= RESET_STATE;
            cur_state_q   <= RESET_STATE;
            cmd_out_q     <= RESET_STATE;
            cmd_valid_q   <= 1'b0;
            req_ready_q   <= 1'b0;
            done_q        <= 1'b0;
            err_illegal_q <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            tgt_q         <= tgt_d;
            cur_state_q   <= cur_state_d;
            cmd_out_q     <= cmd_out_d;
            cmd_valid_q   <= cmd_valid_d;
            req_ready_q   <= req_ready_d;
            done_q        <= done_d;
            err_illegal_q <= err_illegal_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    // Port drive; busy covers the whole issue/confirm window.
    always_comb begin
        req_ready   = req_ready_q;
        cmd_out     = cmd_out_q;
        cmd_valid   = cmd_valid_q;
        cur_state   = cur_state_q;
        busy        = (state_q == ISSUE) || (state_q == WAIT_ECHO);
        done_pulse  = done_q;
        err_illegal = err_illegal_q;
        err_timeout = err_timeout_q;
    end

endmodule

// File: tb/tb_fsm_cmd_driver.sv
module tb_fsm_cmd_driver;
    import fsm_cmd_pkg::*;

    localparam int EL = 3;
    localparam int TO = 8;
    // 0->5, 1->7 and 3->6 are forbidden; everything else is allowed.
    localparam logic [63:0] MASK = ~((64'd1 << 5) | (64'd1 << 15) | (64'd1 << 30));
    localparam logic [MASK_MAX-1:0] MASK_TB = MASK_MAX'(MASK);

    localparam int K_NONE = 0;
    localparam int K_DONE = 1;
    localparam int K_ILL  = 2;
    localparam int K_TO   = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic [2:0] req_state = 3'd0;
    logic       req_ready;
    logic [2:0] cmd_out;
    logic       cmd_valid;
    logic [2:0] status_in = 3'd0;
    logic [2:0] cur_state;
    logic       busy;
    logic       done_pulse;
    logic       err_illegal;
    logic       err_timeout;

    int n_tests = 0;
    int n_fail  = 0;

    logic [2:0] m_cur = 3'd0;
    logic [2:0] m_cmd = 3'd0;

    typedef struct {
        logic [2:0] tgt;
        int         k;
        bit         early;
        int         kind;
        int         lat;
    } vec_t;

    vec_t tbl[9];

    fsm_cmd_driver #(
        .W           (3),
        .ECHO_LAT    (EL),
        .TIMEOUT     (TO),
        .ALLOW_MASK  (MASK),
        .RESET_STATE (3'd0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_state   (req_state),
        .req_ready   (req_ready),
        .cmd_out     (cmd_out),
        .cmd_valid   (cmd_valid),
        .status_in   (status_in),
        .cur_state   (cur_state),
        .busy        (busy),
        .done_pulse  (done_pulse),
        .err_illegal (err_illegal),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got hang expected finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: outcome of one request from the driver's documented rules.
    function automatic void model_txn(input logic [2:0] cur, input logic [2:0] tgt,
                                      input int k, input bit early,
                                      output int kind, output int lat);
        int first;
        if (!legal(MASK_TB, 3, 32'(cur), 32'(tgt))) begin
            kind = K_ILL; lat = 1;
        end else if (tgt == cur) begin
            kind = K_DONE; lat = 1;
        end else begin
            // cmd_valid is live 2 cycles after accept; window opens at count EL-1.
            first = early ? 1000 : ((k > EL - 1) ? k : EL - 1);
            if (first <= EL + TO - 1) begin
                kind = K_DONE; lat = 2 + first + 1;
            end else begin
                kind = K_TO; lat = 2 + EL + TO;
            end
        end
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        req_valid = 1'b0;
        step();
        chk("rst_req_ready_low", req_ready, 0);
        step();
        rst = 1'b0;
        m_cur = 3'd0;
        m_cmd = 3'd0;
        status_in = 3'd0;
        step();
        chk("rst_req_ready", req_ready, 1);
        chk("rst_cur_state", cur_state, 0);
        chk("rst_cmd_out", cmd_out, 0);
        chk("rst_cmd_valid", cmd_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_errs", {done_pulse, err_illegal, err_timeout}, 0);
    endtask

    // Drives one request while acting as the downstream fsm echo; reports what came back.
    // Echo shows tgt from command-live cycle index k onward (or only at index 0 if early).
    task automatic run_txn(input logic [2:0] tgt, input int k, input bit early,
                           output int kind, output int lat, output int cv_c,
                           output logic [2:0] cmd_seen);
        int w;
        kind = K_NONE; lat = 0; cv_c = 0; cmd_seen = cmd_out;
        status_in = m_cur;
        w = 0;
        while (!req_ready && w < 10) begin
            step();
            w++;
        end
        if (!req_ready) begin
            chk("req_ready_wait", req_ready, 1);
            return;
        end
        req_valid = 1'b1;
        req_state = tgt;
        step();
        req_valid = 1'b0;
        cmd_seen = cmd_out;
        for (int c = 1; c <= 30 && kind == K_NONE; c++) begin
            if (cmd_valid && cv_c == 0) begin
                cv_c = c;
                cmd_seen = cmd_out;
            end
            if (done_pulse)       kind = K_DONE;
            else if (err_illegal) kind = K_ILL;
            else if (err_timeout) kind = K_TO;
            if (kind != K_NONE) begin
                lat = c;
            end else begin
                if (early) status_in = (c == 2) ? tgt : m_cur;
                else       status_in = (c >= 2 && c - 2 >= k) ? tgt : m_cur;
                step();
            end
        end
        if (kind == K_NONE) chk("txn_budget", 0, 1);
    endtask

    task automatic expect_txn(input string name, input logic [2:0] tgt, input int k,
                              input bit early, input int exp_kind, input int exp_lat);
        int kind, lat, cv_c;
        logic [2:0] cmd_seen;
        bit is_cmd;
        is_cmd = (exp_kind != K_ILL) && (tgt != m_cur);
        run_txn(tgt, k, early, kind, lat, cv_c, cmd_seen);
        chk({name, "_kind"}, kind, exp_kind);
        chk({name, "_lat"}, lat, exp_lat);
        if (is_cmd) begin
            chk({name, "_cmd_valid_cycle"}, cv_c, 2);
            chk({name, "_cmd_out"}, cmd_seen, tgt);
            m_cmd = tgt;
        end else begin
            chk({name, "_no_cmd"}, cv_c, 0);
            chk({name, "_cmd_hold"}, cmd_seen, m_cmd);
        end
        step();
        chk({name, "_pulse_clear"}, {done_pulse, err_illegal}, 0);
        chk({name, "_busy_after"}, busy, 0);
        chk({name, "_cmd_valid_after"}, cmd_valid, 0);
        if (exp_kind == K_TO) begin
            chk({name, "_ready_locked"}, req_ready, 0);
            chk({name, "_timeout_sticky"}, err_timeout, 1);
        end else begin
            chk({name, "_ready_back"}, req_ready, 1);
        end
        if (exp_kind == K_DONE) m_cur = tgt;
        chk({name, "_cur_state"}, cur_state, m_cur);
    endtask

    initial begin
        int kind, lat, k;
        logic [2:0] tgt;

        // {tgt, echo delay, early-only, expected kind, expected latency from accept}
        tbl[0] = '{3'd3, 2,  1'b0, K_DONE, 5};
        tbl[1] = '{3'd3, 0,  1'b0, K_DONE, 1};
        tbl[2] = '{3'd6, 0,  1'b0, K_ILL,  1};
        tbl[3] = '{3'd1, 0,  1'b0, K_DONE, 5};
        tbl[4] = '{3'd7, 0,  1'b0, K_ILL,  1};
        tbl[5] = '{3'd0, 5,  1'b0, K_DONE, 8};
        tbl[6] = '{3'd5, 0,  1'b0, K_ILL,  1};
        tbl[7] = '{3'd2, 10, 1'b0, K_DONE, 13};
        tbl[8] = '{3'd4, 4,  1'b0, K_DONE, 7};

        do_reset();

        for (int i = 0; i < 9; i++) begin
            expect_txn($sformatf("vec%0d", i), tbl[i].tgt, tbl[i].k, tbl[i].early,
                       tbl[i].kind, tbl[i].lat);
        end

        // Random requests against the reference model; echo delays stay inside the window.
        for (int i = 0; i < 40; i++) begin
            tgt = 3'($urandom_range(0, 7));
            k   = $urandom_range(0, EL + TO - 1);
            repeat ($urandom_range(0, 2)) step();
            model_txn(m_cur, tgt, k, 1'b0, kind, lat);
            expect_txn($sformatf("rnd%0d", i), tgt, k, 1'b0, kind, lat);
        end

        // Echo never arrives: sticky timeout and the driver locks up.
        do_reset();
        expect_txn("timeout", 3'd2, 99, 1'b0, K_TO, 2 + EL + TO);
        req_valid = 1'b1;
        req_state = 3'd0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("err_locked_ready", req_ready, 0);
            chk("err_locked_flag", err_timeout, 1);
            chk("err_locked_busy", busy, 0);
            chk("err_locked_cmd", {cmd_valid, cmd_out}, {1'b0, 3'd2});
        end
        req_valid = 1'b0;

        // Matching echo only at count 0 is not confirmation.
        do_reset();
        expect_txn("early", 3'd4, 0, 1'b1, K_TO, 2 + EL + TO);

        // Reset while waiting for the echo drops the request silently.
        do_reset();
        req_valid = 1'b1;
        req_state = 3'd3;
        step();
        req_valid = 1'b0;
        repeat (3) step();
        chk("midrst_busy_before", busy, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        m_cur = 3'd0;
        m_cmd = 3'd0;
        chk("midrst_cur_state", cur_state, 0);
        chk("midrst_cmd_valid", cmd_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_ready_low", req_ready, 0);
        status_in = 3'd3;
        for (int i = 0; i < 12; i++) begin
            step();
            chk("midrst_no_pulse", {done_pulse, err_illegal, err_timeout}, 0);
        end
        status_in = 3'd0;
        expect_txn("post_rst", 3'd1, 0, 1'b0, K_DONE, 5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
